// File: rtl/gc_pkg.sv
// gc_pkg: shared definitions for the GameCube controller single-wire link.
//   - console command constants (poll is a 24-bit command, init is 8-bit)
//   - transmit FSM state type
//   - default bit-timing quarter (clock cycles per 1 us at 100 MHz)
package gc_pkg;

  localparam int GC_QUARTER_DEFAULT = 100;

  localparam logic [23:0] GC_CMD_POLL = 24'h400300;
  localparam logic [23:0] GC_CMD_INIT = 24'h000000;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_LOW  = 2'd1,
    TX_HIGH = 2'd2,
    TX_STOP = 2'd3
  } gc_tx_state_t;

  // Number of command bits to send for a given length select.
  function automatic logic [4:0] gc_cmd_bits(input logic cmd_long);
    return cmd_long ? 5'd24 : 5'd8;
  endfunction

endpackage

// File: rtl/gc_send_if.sv
// gc_send_if: command/handshake bundle between the APB-side control logic
// (master) and the gc_send transmitter (slave).
//   start    : one-cycle request, sampled only while the transmitter is idle
//   cmd      : 24-bit command, MSB-aligned (8-bit commands use cmd[23:16])
//   cmd_long : 0 = 8-bit command, 1 = 24-bit command
//   line_oe  : 1 = pull the open-drain pad low, 0 = release
//   send     : high for the whole frame including stop bit (to gc_receive)
//   busy     : high whenever a frame is in progress
//   done     : one-cycle pulse at the end of the frame
interface gc_send_if;
  logic        start;
  logic [23:0] cmd;
  logic        cmd_long;
  logic        line_oe;
  logic        send;
  logic        busy;
  logic        done;

  modport master (
    output start, cmd, cmd_long,
    input  line_oe, send, busy, done
  );

  modport slave (
    input  start, cmd, cmd_long,
    output line_oe, send, busy, done
  );
endinterface

// File: rtl/gc_send.sv
// gc_send: transmit half of the GameCube controller single-wire link.
// Serialises an 8- or 24-bit command MSB first as 4*QUARTER-cycle bit cells
// (low QUARTER cycles for a 1, 3*QUARTER for a 0), then a QUARTER-cycle stop
// low. Pad usage: inout = line_oe ? 1'b0 : 1'bz.
// Ports:
//   clk     : system clock, all state on the rising edge
//   PRESERN : asynchronous active-low reset
//   bus     : gc_send_if.slave (start/cmd/cmd_long in, line_oe/send/busy/done out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// TX_IDLE | line released, waiting for start
// TX_LOW  | driving the low part of the current bit cell
// TX_HIGH | released remainder of the cell; shift to next bit at cell end
// TX_STOP | stop bit low for QUARTER cycles, then done
module gc_send
  import gc_pkg::*;
#(
  parameter int QUARTER = GC_QUARTER_DEFAULT
) (
  input  logic       clk,
  input  logic       PRESERN,
  gc_send_if.slave   bus
);

  localparam int CELL = 4 * QUARTER;
  localparam int PW   = $clog2(CELL);

  localparam logic [PW-1:0] LAST_CELL = PW'(CELL - 1);
  localparam logic [PW-1:0] LAST_ONE  = PW'(QUARTER - 1);
  localparam logic [PW-1:0] LAST_ZERO = PW'(3 * QUARTER - 1);

  gc_tx_state_t  state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [4:0]    bits_q, bits_d;
  logic [23:0]   shift_q, shift_d;
  logic          done_d;
  logic          line_oe_q, busy_q, done_q;

  // The phase counter runs across the whole cell; the LOW->HIGH switch is a
  // compare against the bit-dependent low width, so the cell length is fixed.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bits_d  = bits_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (bus.start) begin
          shift_d = bus.cmd;
          bits_d  = gc_cmd_bits(bus.cmd_long);
          phase_d = '0;
          state_d = TX_LOW;
        end
      end
      TX_LOW: begin
        phase_d = phase_q + 1'b1;
        if (phase_q == (shift_q[23] ? LAST_ONE : LAST_ZERO)) begin
          state_d = TX_HIGH;
        end
      end
      TX_HIGH: begin
        if (phase_q == LAST_CELL) begin
          phase_d = '0;
          shift_d = {shift_q[22:0], 1'b0};
          bits_d  = bits_q - 5'd1;
          state_d = (bits_q == 5'd1) ? TX_STOP : TX_LOW;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (phase_q == LAST_ONE) begin
          phase_d = '0;
          done_d  = 1'b1;
          state_d = TX_IDLE;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // Outputs are registered from the next state so the pad driver never
  // sees decode glitches; timing is identical to decoding state_q.
  always_ff @(posedge clk or negedge PRESERN) begin
    if (!PRESERN) begin
      state_q   <= TX_IDLE;
      phase_q   <= '0;
      bits_q    <= '0;
      shift_q   <= '0;
      line_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      bits_q    <= bits_d;
      shift_q   <= shift_d;
      line_oe_q <= (state_d == TX_LOW) || (state_d == TX_STOP);
      busy_q    <= (state_d != TX_IDLE);
      done_q    <= done_d;
    end
  end

  assign bus.line_oe = line_oe_q;
  assign bus.busy    = busy_q;
  assign bus.send    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_gc_send.sv
module tb_gc_send;
  import gc_pkg::*;

  localparam int Q    = GC_QUARTER_DEFAULT;
  localparam int CELL = 4 * Q;

  logic clk = 1'b0;
  logic PRESERN;
  int   errors = 0;
  int   checks = 0;

  gc_send_if bus ();

  gc_send #(.QUARTER(Q)) dut (
    .clk     (clk),
    .PRESERN (PRESERN),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pad drive t cycles after the edge that accepted start.
  function automatic logic exp_oe(input logic [23:0] c, input int n, input int t);
    int len, k, w;
    len = n * CELL + Q;
    if (t >= len) return 1'b0;
    k = t / CELL;
    w = t % CELL;
    if (k < n) return (w < (c[23-k] ? Q : 3 * Q));
    return (w < Q);
  endfunction

  // Sends one frame and checks it cycle by cycle. Returns at the sample
  // taken just after the done edge. pre=1: start was already accepted on the
  // edge just before the call. extra_at: edge offset at which a second start
  // is presented (ignored by a correct design).
  task automatic frame(input logic [23:0] c, input bit lng, input bit pre,
                       input int extra_at, input logic [23:0] extra_cmd, input string tag);
    int n, len, oe_err, sb_err, done_cnt, done_t, run, bad_w, stop_w, nlow;
    logic [23:0] dec, expv;
    n = lng ? 24 : 8;
    len = n * CELL + Q;
    oe_err = 0; sb_err = 0; done_cnt = 0; done_t = -1; run = 0;
    bad_w = 0; stop_w = 0; nlow = 0; dec = '0;
    if (!pre) begin
      bus.cmd = c; bus.cmd_long = lng; bus.start = 1'b1;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    bus.cmd = 24'($urandom);
    bus.cmd_long = 1'($urandom_range(0, 1));
    for (int t = 0; t <= len; t++) begin
      if (t == 0) begin
        check({tag, ":lat_oe"}, 32'(bus.line_oe), 32'd1);
        check({tag, ":lat_busy"}, 32'(bus.busy), 32'd1);
      end
      if (bus.line_oe !== exp_oe(c, n, t)) oe_err++;
      if (bus.send !== (t < len) || bus.busy !== (t < len)) sb_err++;
      if (bus.done === 1'b1) begin done_cnt++; done_t = t; end
      if (bus.line_oe === 1'b1) run++;
      else if (run > 0) begin
        nlow++;
        if (nlow <= n) begin
          if (run == Q) dec = {dec[22:0], 1'b1};
          else if (run == 3 * Q) dec = {dec[22:0], 1'b0};
          else bad_w++;
        end else stop_w = run;
        run = 0;
      end
      if (t < len) begin
        bus.start = (t + 1 == extra_at);
        if (t + 1 == extra_at) begin bus.cmd = extra_cmd; bus.cmd_long = 1'b1; end
        @(posedge clk); #1;
      end
    end
    bus.start = 1'b0;
    expv = lng ? c : {16'h0, c[23:16]};
    check({tag, ":oe_wave_errs"}, 32'(oe_err), 32'd0);
    check({tag, ":send_busy_errs"}, 32'(sb_err), 32'd0);
    check({tag, ":done_count"}, 32'(done_cnt), 32'd1);
    check({tag, ":done_time"}, 32'(done_t), 32'(len));
    check({tag, ":low_pulses"}, 32'(nlow), 32'(n + 1));
    check({tag, ":bad_widths"}, 32'(bad_w), 32'd0);
    check({tag, ":decoded"}, 32'(dec), 32'(expv));
    check({tag, ":stop_width"}, 32'(stop_w), 32'(Q));
  endtask

  // Line must stay idle with no done pulse for the given cycles.
  task automatic idle_check(input int cycles, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.busy !== 1'b0 || bus.send !== 1'b0 || bus.done !== 1'b0 || bus.line_oe !== 1'b0) bad++;
    end
    check({tag, ":idle_errs"}, 32'(bad), 32'd0);
  endtask

  initial begin
    logic [23:0] rc;
    bit          rl;
    PRESERN = 1'b0;
    bus.start = 1'b0;
    bus.cmd = '0;
    bus.cmd_long = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst:line_oe", 32'(bus.line_oe), 32'd0);
    check("rst:send", 32'(bus.send), 32'd0);
    check("rst:busy", 32'(bus.busy), 32'd0);
    check("rst:done", 32'(bus.done), 32'd0);
    PRESERN = 1'b1;
    @(posedge clk); #1;

    frame(GC_CMD_INIT, 1'b0, 1'b0, -1, '0, "init");
    idle_check(3, "post_init");
    frame(GC_CMD_POLL, 1'b1, 1'b0, -1, '0, "poll");
    idle_check(2, "post_poll");
    frame(24'hFF0000, 1'b0, 1'b0, -1, '0, "ones");
    idle_check(2, "post_ones");

    frame(24'h5A0000, 1'b0, 1'b0, 500, 24'hFFFFFF, "busy_ign");
    idle_check(5, "no_queue");

    // reset inside a low phase of an init frame
    bus.cmd = GC_CMD_INIT; bus.cmd_long = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (1233) begin @(posedge clk); #1; end
    check("midrst:pre_oe", 32'(bus.line_oe), 32'(exp_oe(GC_CMD_INIT, 8, 1233)));
    #2 PRESERN = 1'b0;
    #1;
    check("midrst:line_oe", 32'(bus.line_oe), 32'd0);
    check("midrst:send", 32'(bus.send), 32'd0);
    check("midrst:busy", 32'(bus.busy), 32'd0);
    idle_check(3, "midrst_hold");
    PRESERN = 1'b1;
    idle_check(3, "midrst_after");
    frame(GC_CMD_INIT, 1'b0, 1'b0, -1, '0, "after_rst");
    idle_check(1, "post_after_rst");

    // start coincident with the done edge is ignored
    frame(24'hC30000, 1'b0, 1'b0, 8 * CELL + Q, 24'hFFFFFF, "coinc");
    idle_check(4, "coinc_ignored");

    // start one cycle after the done edge is accepted
    frame(24'h810000, 1'b0, 1'b0, -1, '0, "pre_done");
    check("next:done_seen", 32'(bus.done), 32'd1);
    bus.cmd = 24'h3C0000; bus.cmd_long = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1;
    frame(24'h3C0000, 1'b0, 1'b1, -1, '0, "next_cycle");
    idle_check(1, "post_next");

    for (int i = 0; i < 3; i++) begin
      rc = 24'($urandom);
      rl = 1'($urandom_range(0, 1));
      frame(rc, rl, 1'b0, -1, '0, $sformatf("rand%0d", i));
      idle_check(1, $sformatf("post_rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
